// File: rtl/datamem_arb_pkg.sv
// Shared types and constants for the two-port datamem arbiter.
package datamem_arb_pkg;

    localparam int unsigned DEF_ADDRESS_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH    = 32;

    // One memory request at the default datamem geometry.
    typedef struct packed {
        logic                         we;
        logic [DEF_ADDRESS_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0]    wdata;
    } mem_req_t;

    localparam logic PORT0            = 1'b0;
    localparam logic PORT1            = 1'b1;
    // Port 0 wins the first contested cycle after reset.
    localparam logic RESET_LAST_GRANT = PORT1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant generator: round-robin, or port 0 always wins when FIXED_PRIO != 0.
module rr_arb2 #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);
    import datamem_arb_pkg::*;

    logic last_grant_q;
    logic prefer0;

    // Combinational grant; nothing is granted while reset is held.
    always_comb begin
        prefer0 = (FIXED_PRIO != 0) || (last_grant_q == PORT1);
        grant0  = rst_n & valid0 & (~valid1 | prefer0);
        grant1  = rst_n & valid1 & ~grant0;
    end

    // Remember the last granted port; hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= RESET_LAST_GRANT;
        end else if (grant0) begin
            last_grant_q <= PORT0;
        end else if (grant1) begin
            last_grant_q <= PORT1;
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// Shares single-port synchronous-read datamem between the LSU (port 0) and a
// debug/DMA loader (port 1). Reads return one cycle after acceptance.
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned FIXED_PRIO    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic                     req0_we,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]    req0_wdata,
    output logic                     rsp0_valid,
    output logic [DATA_WIDTH-1:0]    rsp0_rdata,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic                     req1_we,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]    req1_wdata,
    output logic                     rsp1_valid,
    output logic [DATA_WIDTH-1:0]    rsp1_rdata,

    output logic                     mem_wr_en,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    // Same shape as mem_req_t, but following this instance's widths.
    typedef struct packed {
        logic                     we;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    wdata;
    } req_t;

    logic grant0;
    logic grant1;
    req_t req_sel;
    logic rd_accept;
    logic rd_tag;
    logic rsp_pending_q;
    logic rsp_tag_q;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Request mux; an idle cycle issues a harmless read of address 0.
    always_comb begin
        req_sel = '0;
        if (grant0) begin
            req_sel = '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
        end else if (grant1) begin
            req_sel = '{we: req1_we, addr: req1_addr, wdata: req1_wdata};
        end
        mem_wr_en = req_sel.we;
        mem_addr  = req_sel.addr;
        mem_wd    = req_sel.wdata;
    end

    // Identify an accepted read and which port issued it.
    always_comb begin
        rd_accept = (grant0 & ~req0_we) | (grant1 & ~req1_we);
        rd_tag    = grant1 ? PORT1 : PORT0;
    end

    // Tag pipeline lines up with datamem's registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pending_q <= 1'b0;
            rsp_tag_q     <= PORT0;
        end else begin
            rsp_pending_q <= rd_accept;
            if (rd_accept) begin
                rsp_tag_q <= rd_tag;
            end
        end
    end

    // Route read data to the tagged port; rdata is zero when not valid.
    always_comb begin
        rsp0_valid = rsp_pending_q & (rsp_tag_q == PORT0);
        rsp1_valid = rsp_pending_q & (rsp_tag_q == PORT1);
        rsp0_rdata = rsp0_valid ? mem_rd : '0;
        rsp1_rdata = rsp1_valid ? mem_rd : '0;
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Self-checking bench for datamem_arbiter with a behavioural datamem and a
// scoreboard of expected read responses.
module tb_datamem_arbiter;
    import datamem_arb_pkg::*;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we;
    logic [31:0] req0_addr, req0_wdata;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    // Fixed-priority instance shares the request inputs; only its readies are checked.
    logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_mem_wr_en;
    logic [31:0] fp_rsp0_rdata, fp_rsp1_rdata, fp_mem_addr, fp_mem_wd;

    always #5 clk = ~clk;

    datamem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    datamem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(1)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(fp_rsp0_valid), .rsp0_rdata(fp_rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(fp_rsp1_valid), .rsp1_rdata(fp_rsp1_rdata),
        .mem_wr_en(fp_mem_wr_en), .mem_addr(fp_mem_addr), .mem_wd(fp_mem_wd),
        .mem_rd(32'h0)
    );

    // datamem: synchronous read, rd holds its value on write cycles.
    logic [31:0] dm [256];
    always @(posedge clk) begin
        if (mem_wr_en) dm[mem_addr[7:0]] <= mem_wd;
        else           mem_rd <= dm[mem_addr[7:0]];
    end

    int          n_checks;
    int          n_errors;
    logic        model_last;
    logic [31:0] ref_mem [256];
    exp_t        sb [$];
    logic        cur_v0, cur_v1;
    logic [31:0] cur_d0, cur_d1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic we0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic v1, input logic we1,
                         input logic [31:0] a1, input logic [31:0] d1);
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    endtask

    task automatic clear_model();
        sb.delete();
        cur_v0 = 1'b0; cur_v1 = 1'b0; cur_d0 = '0; cur_d1 = '0;
        model_last = PORT1;
    endtask

    task automatic check_rsp(input string sfx);
        check_eq({"rsp0_valid", sfx}, {31'd0, rsp0_valid}, {31'd0, cur_v0});
        check_eq({"rsp0_rdata", sfx}, rsp0_rdata, cur_v0 ? cur_d0 : 32'h0);
        check_eq({"rsp1_valid", sfx}, {31'd0, rsp1_valid}, {31'd0, cur_v1});
        check_eq({"rsp1_rdata", sfx}, rsp1_rdata, cur_v1 ? cur_d1 : 32'h0);
    endtask

    // One clock of traffic: check grants and memory drive, then the response.
    task automatic step(input logic v0, input logic we0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic v1, input logic we1,
                        input logic [31:0] a1, input logic [31:0] d1);
        logic        e0, e1, xwe;
        logic [31:0] xa, xd;
        exp_t        e;
        @(negedge clk);
        drive(v0, we0, a0, d0, v1, we1, a1, d1);
        #1;
        check_rsp("_hold");
        e0 = v0 && (!v1 || model_last == PORT1);
        e1 = v1 && !e0;
        check_eq("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
        check_eq("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
        check_eq("fp_req0_ready", {31'd0, fp_req0_ready}, {31'd0, v0});
        check_eq("fp_req1_ready", {31'd0, fp_req1_ready}, {31'd0, v1 && !v0});
        xwe = 1'b0; xa = '0; xd = '0;
        if (e0) begin xwe = we0; xa = a0; xd = d0; end
        if (e1) begin xwe = we1; xa = a1; xd = d1; end
        check_eq("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, xwe});
        check_eq("mem_addr", mem_addr, xa);
        check_eq("mem_wd", mem_wd, xd);
        if (e0 || e1) begin
            model_last = e1 ? PORT1 : PORT0;
            if (xwe) ref_mem[xa[7:0]] = xd;
            else     sb.push_back('{port: e1, data: ref_mem[xa[7:0]]});
        end
        @(posedge clk);
        #1;
        cur_v0 = 1'b0; cur_v1 = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port == PORT0) begin cur_v0 = 1'b1; cur_d0 = e.data; end
            else                 begin cur_v1 = 1'b1; cur_d1 = e.data; end
        end
        check_rsp("");
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        clear_model();

        // Reset held with both ports requesting: nothing granted, no responses.
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_eq("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
            check_eq("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
            check_eq("rst_fp_req0_ready", {31'd0, fp_req0_ready}, 32'd0);
            check_rsp("_rst");
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;

        // Contested first cycle goes to port 0; port 1 holds until served.
        step(1'b1, 1'b1, 32'h4, 32'h11, 1'b1, 1'b1, 32'h8, 32'h22);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h8, 32'h22);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h55);

        // Write then read of the same address on port 0.
        step(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);

        // Continuous contention: round-robin alternates, fixed priority keeps port 0.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
        end

        // Port 0 drops: port 1 served at once; then read-before-write on 0x20.
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        step(1'b1, 1'b1, 32'h20, 32'h99, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset between acceptance and the following edge drops the response.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_eq("mid_req0_ready", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("mid_rsp0_valid_pre", {31'd0, rsp0_valid}, 32'd1);
        check_eq("mid_rsp0_rdata_pre", rsp0_rdata, ref_mem[4]);
        rst_n = 1'b0;
        clear_model();
        #1;
        check_rsp("_mid_rst");
        check_eq("mid_req0_ready_rst", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Last grant was restored by reset: port 0 wins again.
        step(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
Two-port arbiter sharing the single-port, synchronous-read data memory (datamem) between two requesters: port 0 is the core load/store unit and port 1 is a debug/DMA loader. It accepts one request per cycle over a valid/ready handshake and drives datamem's wr_en/addr/wd. It routes datamem's registered rd back to the issuing requester one cycle later. Arbitration is round-robin or fixed-priority, set by parameter.

Parameters:
ADDRESS_WIDTH, 32, address width; matches datamem.
DATA_WIDTH, 32, data width; matches datamem.
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req0_valid  in  1  port 0 request present.
req0_ready  out  1  port 0 request accepted this cycle.
req0_we  in  1  port 0: 1 = write, 0 = read.
req0_addr  in  ADDRESS_WIDTH  port 0 address.
req0_wdata  in  DATA_WIDTH  port 0 write data.
rsp0_valid  out  1  port 0 read data valid.
rsp0_rdata  out  DATA_WIDTH  port 0 read data.
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1.
mem_wr_en  out  1  to datamem wr_en.
mem_addr  out  ADDRESS_WIDTH  to datamem addr.
mem_wd  out  DATA_WIDTH  to datamem wd.
mem_rd  in  DATA_WIDTH  from datamem rd; registered inside datamem.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: rsp0_valid = rsp1_valid = 0; last_grant = 1, so port 0 wins the first contested cycle; rsp_pending = 0; rsp_tag = 0.
- Grant logic is combinational from reqX_valid and last_grant.
  - Only one port valid: that port is granted.
  - Both valid, FIXED_PRIO=0: grant the port != last_grant.
  - Both valid, FIXED_PRIO=1: grant port 0.
  - Neither valid: no grant.
- reqX_ready = grant to X. The transfer occurs when valid && ready. ready never asserts without valid. During rst_n=0 both readies are 0.
- Memory drive:
  - Granted: mem_wr_en = granted we; mem_addr and mem_wd = granted port's addr and wdata.
  - No grant: mem_wr_en = 0, mem_addr = 0, mem_wd = 0. This issues a harmless read of address 0, which is ignored.
- last_grant updates on every granted cycle, reads and writes alike. It holds when idle.
- Write handshake: complete on acceptance. No response. Memory is updated at the same clock edge.
- Read response pipeline:
  - On an accepted read, register rsp_pending = 1 and rsp_tag = granted port.
  - In the next cycle, rsp<tag>_valid = 1 and rsp<tag>_rdata = mem_rd.
  - Latency is exactly 1 cycle from acceptance edge to data.
- Back-to-back reads, same or alternating ports, give one response per cycle in acceptance order. Throughput is 1 access per cycle.
- A read followed immediately by a write: the read response is still valid in the write cycle. mem_rd carries the previous read's result because datamem does not update rd on write cycles.
- A write followed by a read of the same address returns the new data.
- rspX_rdata = 0 whenever rspX_valid = 0. Responses cannot be back-pressured.
- Starvation bound (round-robin): with both ports continuously valid, grants strictly alternate. Each port waits at most 1 cycle.
- A requester must hold valid, we, addr and wdata stable until ready. The arbiter does not latch unaccepted requests.
- Reset asserted mid-operation: a pending read response is dropped (rsp_valid forced 0 asynchronously) and last_grant returns to 1.

Decomposition:
- Package datamem_arb_pkg holds:
  - typedef mem_req_t: struct of we, addr, wdata, sized by ADDRESS_WIDTH/DATA_WIDTH defaults.
  - Constants PORT0 = 1'b0, PORT1 = 1'b1, RESET_LAST_GRANT = PORT1.
- One sub-module, rr_arb2: a 2-way round-robin/fixed-priority grant generator holding last_grant.
- The top level does the request mux, response tag pipeline and rdata routing.

Test Plan:
- Reset: hold rst_n=0 with both valid -> both ready=0, both rsp_valid=0. Release rst_n; both valid -> port 0 granted first.
- Write then read: port0 writes 0xDEADBEEF to addr 0x10, then reads 0x10 the next cycle -> rsp0_valid=1 one cycle after the read is accepted, rsp0_rdata=0xDEADBEEF, rsp1_valid=0.
- Contention, round-robin: both ports read continuously, port0 addr 0x4 (holds 0x11), port1 addr 0x8 (holds 0x22) -> grants alternate 0,1,0,1; responses alternate 0x11 on port 0 and 0x22 on port 1, each 1 cycle after its grant.
- FIXED_PRIO=1: both valid for 4 cycles -> port 0 granted all 4 cycles and port 1 stalls. Drop req0_valid -> port 1 granted the same cycle.
- Read then write: port1 reads 0x20 (holds 0x55), port0 writes 0x99 to 0x20 the next cycle -> rsp1_rdata=0x55 in the write cycle; a later read of 0x20 returns 0x99.
- Reset mid-read: a read is accepted, then rst_n is asserted before the next edge -> rsp_valid stays 0 and no response is delivered after release.
